mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-ported program/data memory between the instruction-fetch path (IF) and the load/store path (LS) of the core. Arbitrates requests, issues one memory access at a time, and waits a fixed memory latency. Returns read data, or a write acknowledge, to the winning requester with a one-cycle valid pulse. Sits between the control unit's fetch/execute datapath and the memory macro.

Parameters:
ADDR_W, 8, address width of both requesters and the memory port
DATA_W, 8, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15
STARVE_MAX, 3, consecutive LS wins over a waiting IF before IF is forced; legal range 1..15

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch request, level; held with if_addr until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  one-cycle pulse: IF access issued this cycle
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  DATA_W  fetched word
ls_req  input  1  load/store request, level; held with ls_we/ls_addr/ls_wdata until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  load/store address
ls_wdata  input  DATA_W  store data
ls_gnt  output  1  one-cycle pulse: LS access issued this cycle
ls_rvalid  output  1  one-cycle pulse: load data valid / store complete
ls_rdata  output  DATA_W  load data; 0 on store completion
mem_en  output  1  memory access strobe, one cycle
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (async, any time, including mid-access): state=IDLE, starve counter=0, owner=IF, wait counter=0. All outputs 0; rdata registers 0. The in-flight access is dropped and no rvalid is produced.
- FSM: IDLE -> GRANT -> WAIT -> RESP -> IDLE.
- IDLE: arbitrate on the registered request state at the clock edge. If no request, stay in IDLE. Otherwise latch owner, addr, we (IF forces we=0) and wdata, then go to GRANT.
- Default arbitration is fixed priority, LS over IF.
  - Exception: if both request and starve counter == STARVE_MAX, IF wins.
  - Starve counter increments (saturating at STARVE_MAX) when LS wins while if_req=1.
  - Starve counter clears when IF wins.
  - Starve counter is unchanged when LS wins with if_req=0.
- GRANT (1 cycle): mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched values; owner's gnt=1. Load wait counter with MEM_LAT. Go to WAIT.
- WAIT (exactly MEM_LAT cycles): mem_en=0. mem_addr/mem_wdata hold their latched values; mem_we=0.
  - At the edge ending the last WAIT cycle, capture mem_rdata into the owner's rdata register. On a write, capture 0 instead.
  - Go to RESP.
- RESP (1 cycle): owner's rvalid=1 and rdata stable. The non-owner's rdata register keeps its previous value. Go to IDLE.
- Latency: req sampled in cycle 0 -> gnt/mem_en in cycle 1 -> rvalid in cycle MEM_LAT+2. Back-to-back throughput is one access per MEM_LAT+3 cycles.
- Request handling:
  - Requests arriving while busy=1 are ignored until the next IDLE edge.
  - A requester must drop req in the cycle after gnt unless it wants another access.
  - A request withdrawn before an IDLE edge is never granted.
- Never both gnt high together; never both rvalid high together.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: fixed priority and the starve counter are removed.
  - On contention, the requester that did not win the last contended arbitration wins.
  - After reset, LS wins the first contention.
  - An uncontended grant does not change the RR pointer.
- Undefined: fixed LS priority with STARVE_MAX anti-starvation, as above.

Test Plan:
- Reset then idle, no requests for 10 cycles -> all outputs 0, busy=0.
- if_req=1, if_addr=0x10, memory returns 0xA5 -> if_gnt and mem_en at cycle 1 with mem_addr=0x10, mem_we=0; if_rvalid at cycle 4 with if_rdata=0xA5.
- ls_req=1, ls_we=1, ls_addr=0x20, ls_wdata=0x3C -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x3C, ls_gnt=1; cycle 4: ls_rvalid=1, ls_rdata=0x00.
- if_req and ls_req held continuously, fixed priority -> grant order LS, LS, LS, IF, LS, LS, LS, IF; each IF grant follows exactly 3 LS grants.
- With MEM_ARB_ROUND_ROBIN_EN defined, both requests held continuously -> grants alternate LS, IF, LS, IF.
- Assert reset during WAIT of an LS load, release it, then issue if_req -> no ls_rvalid ever appears; the IF access completes with the normal cycle-4 timing relative to its request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_LD = 4'(MEM_LAT);

    state_t     state;
    logic       owner_ls;
    logic       acc_we;
    logic [3:0] wait_cnt;
    logic       pick_ls;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_ls_next;

    // On contention the side that lost the previous contended round wins.
    always_comb begin
        pick_ls = ls_req & (~if_req | rr_ls_next);
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;

    // LS has priority unless IF has already lost STARVE_MAX rounds in a row.
    always_comb begin
        pick_ls = ls_req & ~(if_req & (starve_cnt == STARVE_LIM));
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            owner_ls  <= 1'b0;
            acc_we    <= 1'b0;
            wait_cnt  <= '0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ls_next <= 1'b1;
`else
            starve_cnt <= '0;
`endif
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req | ls_req) begin
                        owner_ls  <= pick_ls;
                        acc_we    <= pick_ls & ls_we;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_ls & ls_we;
                        mem_addr  <= pick_ls ? ls_addr : if_addr;
                        mem_wdata <= pick_ls ? ls_wdata : '0;
                        if_gnt    <= ~pick_ls;
                        ls_gnt    <= pick_ls;
                        busy      <= 1'b1;
                        state     <= S_GRANT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        if (if_req & ls_req)
                            rr_ls_next <= ~pick_ls;
`else
                        if (!pick_ls)
                            starve_cnt <= '0;
                        else if (if_req && starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 4'd1;
`endif
                    end
                end
                S_GRANT: begin
                    mem_we   <= 1'b0;
                    wait_cnt <= LAT_LD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wait_cnt <= '0;
                        state    <= S_RESP;
                        if (owner_ls) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= acc_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W = 8, DATA_W = 8, MEM_LAT = 2, STARVE_MAX = 3;

    logic clk = 1'b0, reset = 1'b1;
    logic if_req = 0, ls_req = 0, ls_we = 0;
    logic [ADDR_W-1:0] if_addr = '0, ls_addr = '0, mem_addr;
    logic [DATA_W-1:0] ls_wdata = '0, if_rdata, ls_rdata, mem_wdata, mem_rdata;
    logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Memory macro: reads appear MEM_LAT cycles after mem_en, junk otherwise.
    logic [DATA_W-1:0] macro_mem [256];
    logic [DATA_W-1:0] ref_mem [256];
    logic [ADDR_W-1:0] pa [MEM_LAT];
    logic              pv [MEM_LAT];
    logic [DATA_W-1:0] junk = 8'h5A;

    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (mem_en && mem_we) macro_mem[mem_addr] <= mem_wdata;
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            pa[i] <= pa[i-1];
            pv[i] <= pv[i-1];
        end
        pa[0] <= mem_addr;
        pv[0] <= mem_en & ~mem_we;
    end
    assign mem_rdata = pv[MEM_LAT-1] ? macro_mem[pa[MEM_LAT-1]] : junk;

    // Scoreboard state
    typedef struct { bit ls; logic [DATA_W-1:0] rdata; int due; } resp_t;
    resp_t rq[$];
    byte   glog[$];
    bit    pend_valid = 0, pend_ls, pend_we, w_ls, exp_gnt, exp_irv, exp_lrv;
    int    pend_cycle, ready_cycle = 0, starve = 0;
    bit    rr_ls_first = 1;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata, rd, exp_if_rdata = '0, exp_ls_rdata = '0;
    bit    if_gnt_seen = 0, ls_gnt_seen = 0, busy_seen = 0;

    always @(negedge clk) begin
        if (reset) begin
            rq.delete();
            pend_valid = 0; ready_cycle = cycle; starve = 0; rr_ls_first = 1;
            exp_if_rdata = '0; exp_ls_rdata = '0;
            if_gnt_seen = 0; ls_gnt_seen = 0; busy_seen = 0;
            chk("reset_ctl", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, busy}), 32'd0);
            chk("reset_data", {mem_addr, mem_wdata, if_rdata, ls_rdata}, 32'd0);
        end else begin
            exp_gnt = pend_valid && pend_cycle == cycle;
            chk("gnt_any", 32'(if_gnt | ls_gnt), 32'(exp_gnt));
            chk("gnt_excl", 32'(if_gnt & ls_gnt), 32'd0);
            chk("mem_en", 32'(mem_en), 32'(exp_gnt));
            if (exp_gnt) begin
                chk("gnt_owner_ls", 32'(ls_gnt), 32'(pend_ls));
                chk("mem_addr", 32'(mem_addr), 32'(pend_addr));
                chk("mem_we", 32'(mem_we), 32'(pend_we));
                if (pend_we) chk("mem_wdata", 32'(mem_wdata), 32'(pend_wdata));
                rd = pend_we ? '0 : ref_mem[pend_addr];
                if (pend_we) ref_mem[pend_addr] = pend_wdata;
                rq.push_back('{pend_ls, rd, cycle + MEM_LAT + 1});
                ready_cycle = cycle + MEM_LAT + 2;
                pend_valid = 0;
                glog.push_back(pend_ls ? 8'h4C : 8'h49);
            end else begin
                chk("mem_we_idle", 32'(mem_we), 32'd0);
            end
            exp_irv = 0; exp_lrv = 0;
            if (rq.size() > 0 && rq[0].due <= cycle) begin
                if (rq[0].ls) begin exp_lrv = 1; exp_ls_rdata = rq[0].rdata; end
                else          begin exp_irv = 1; exp_if_rdata = rq[0].rdata; end
                void'(rq.pop_front());
            end
            chk("if_rvalid", 32'(if_rvalid), 32'(exp_irv));
            chk("ls_rvalid", 32'(ls_rvalid), 32'(exp_lrv));
            chk("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
            chk("ls_rdata", 32'(ls_rdata), 32'(exp_ls_rdata));
            chk("busy", 32'(busy), 32'(cycle < ready_cycle));
            // Predict the arbitration made at the coming edge from the visible requests.
            if (!pend_valid && cycle >= ready_cycle && (if_req || ls_req)) begin
                if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    w_ls = rr_ls_first;
                    rr_ls_first = !w_ls;
`else
                    w_ls = (starve != STARVE_MAX);
                    if (w_ls) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
                    else      starve = 0;
`endif
                end else begin
                    w_ls = ls_req;
                    if (!w_ls) starve = 0;
                end
                pend_valid = 1; pend_cycle = cycle + 1; pend_ls = w_ls;
                pend_addr  = w_ls ? ls_addr : if_addr;
                pend_we    = w_ls & ls_we;
                pend_wdata = ls_wdata;
            end
            if_gnt_seen = if_gnt; ls_gnt_seen = ls_gnt; busy_seen = busy;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt(input bit is_ls);
        int n = 0;
        do begin tick(); n++; end while (!(is_ls ? ls_gnt_seen : if_gnt_seen) && n < 50);
        chk(is_ls ? "ls_gnt_timeout" : "if_gnt_timeout", 32'(n < 50), 32'd1);
    endtask

    string exp_order;
    bit if_act = 0, ls_act = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            macro_mem[i] = 8'($urandom);
            ref_mem[i]   = macro_mem[i];
        end
        for (int i = 0; i < MEM_LAT; i++) begin pv[i] = 0; pa[i] = '0; end
        repeat (3) tick();
        reset = 0;
        repeat (10) tick();
        @(negedge clk);
        chk("idle_all_zero", {mem_addr, mem_wdata, if_rdata[6:0], busy}, 32'd0);
        chk("idle_ctl_zero", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, ls_rdata}), 32'd0);
        tick();

        // Single fetch of 0x10 returning 0xA5
        macro_mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        if_req = 1; if_addr = 8'h10;
        wait_gnt(0); if_req = 0;
        repeat (6) tick();

        // Store 0x3C to 0x20
        ls_req = 1; ls_we = 1; ls_addr = 8'h20; ls_wdata = 8'h3C;
        wait_gnt(1); ls_req = 0; ls_we = 0;
        repeat (6) tick();

        // Both held continuously
        glog.delete();
        if_req = 1; if_addr = 8'h20; ls_req = 1; ls_we = 0; ls_addr = 8'h10;
        for (int n = 0; n < 100 && glog.size() < 8; n++) tick();
        if_req = 0; ls_req = 0;
        repeat (8) tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = "LILILILI";
`else
        exp_order = "LLLILLLI";
`endif
        for (int i = 0; i < 8; i++)
            chk("grant_order", 32'((glog.size() > i) ? glog[i] : 8'h3F), 32'(exp_order[i]));

        // Reset during WAIT of a load, then a fetch
        ls_req = 1; ls_we = 0; ls_addr = 8'h30;
        wait_gnt(1); ls_req = 0;
        reset = 1; tick(); reset = 0;
        if_req = 1; if_addr = 8'h44;
        wait_gnt(0); if_req = 0;
        repeat (8) tick();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            tick();
            if (if_act) begin
                if (if_gnt_seen || (busy_seen && $urandom_range(0, 15) == 0)) begin if_req = 0; if_act = 0; end
            end else if ($urandom_range(0, 3) == 0) begin
                if_req = 1; if_addr = 8'($urandom); if_act = 1;
            end
            if (ls_act) begin
                if (ls_gnt_seen || (busy_seen && $urandom_range(0, 15) == 0)) begin ls_req = 0; ls_act = 0; end
            end else if ($urandom_range(0, 2) == 0) begin
                ls_req = 1; ls_we = 1'($urandom); ls_addr = 8'($urandom); ls_wdata = 8'($urandom); ls_act = 1;
            end
        end
        if_req = 0; ls_req = 0;
        repeat (10) tick();
        chk("queue_drained", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
